// File: rtl/aesl_dl_pkg.sv
// Shared types and constants for the deadlock token scheduler.
//   sched_state_e   : scheduler FSM state encoding
//   rr_idx_t        : round-robin pointer / process index (covers up to MAX_PROC_NUM)
//   onehot_to_idx() : converts a one-hot grant into its index
package aesl_dl_pkg;

  localparam int DEF_STALL_THRESH = 16;
  localparam int DEF_HOLD_MAX     = 64;
  localparam int MAX_PROC_NUM     = 32;
  localparam int RR_IDX_W         = 5;

  typedef logic [RR_IDX_W-1:0] rr_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } sched_state_e;

  function automatic rr_idx_t onehot_to_idx(input logic [MAX_PROC_NUM-1:0] v);
    rr_idx_t r;
    r = '0;
    for (int i = 0; i < MAX_PROC_NUM; i++) begin
      if (v[i]) r = rr_idx_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/aesl_dl_rr_arbiter.sv
// Combinational round-robin picker.
//   req : request vector (N bits)
//   ptr : index of the last winner; the search starts at ptr+1 and wraps
//   gnt : one-hot winner, or zero when no request is set
module aesl_dl_rr_arbiter
  import aesl_dl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  rr_idx_t      ptr,
  output logic [N-1:0] gnt
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  always_comb begin
    logic [N-1:0] pick;
    logic [N-1:0] req_sh;
    int unsigned  j;
    pick   = '0;
    req_sh = '0;
    j      = 0;
    // Walk from the farthest offset back to ptr+1 so the closest request
    // after ptr is the last one written and therefore wins.
    for (int k = N; k >= 1; k--) begin
      j      = (int'(ptr) + k) % N;
      req_sh = req >> j;
      if (req_sh[0]) pick = ONE << j;
    end
    gnt = pick;
  end

endmodule

// File: rtl/aesl_deadlock_token_sched.sv
// Deadlock probe-token scheduler.
// Tracks how long each process has been blocked, and hands a one-hot probe
// token to one stalled process at a time (round-robin) so the deadlock report
// unit can examine it.
//
// Ports:
//   clock, reset   : single rising-edge clock, synchronous active-high reset
//   proc_blk       : per-process blocked indicator
//   token_clear    : report unit finished the current probe
//   dl_detect_in   : sticky detection flag; freezes the stall counters
//   token_grant    : one-hot probe token (nonzero only in HOLD)
//   dl_in_vec      : token_grant & stalled, one cycle behind token_grant
//   sched_busy     : FSM not in IDLE
//   hold_timeout   : sticky, set when a HOLD lasted HOLD_MAX cycles
//   global_stall   : registered &stalled when AESL_DL_GLOBAL_STALL_EN is
//                    defined, otherwise tied to 0
module aesl_deadlock_token_sched
  import aesl_dl_pkg::*;
#(
  parameter int PROC_NUM     = 4,
  parameter int STALL_THRESH = DEF_STALL_THRESH,
  parameter int CNT_W        = 8,
  parameter int HOLD_MAX     = DEF_HOLD_MAX
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] proc_blk,
  input  logic                token_clear,
  input  logic                dl_detect_in,
  output logic [PROC_NUM-1:0] token_grant,
  output logic [PROC_NUM-1:0] dl_in_vec,
  output logic                sched_busy,
  output logic                hold_timeout,
  output logic                global_stall
);

  localparam int HC_W = $clog2(HOLD_MAX + 1);

  logic [CNT_W-1:0]    cnt [PROC_NUM];
  logic [PROC_NUM-1:0] stalled;
  logic [PROC_NUM-1:0] arb_gnt;
  logic [MAX_PROC_NUM-1:0] arb_gnt_wide;
  sched_state_e        state;
  rr_idx_t             ptr;
  rr_idx_t             grant_idx;
  logic [HC_W-1:0]     hold_cnt;
  logic                granted_stalled;

  // Stall counters: count consecutive blocked cycles, saturate, and freeze
  // while the report unit holds its detection flag.
  always_ff @(posedge clock) begin
    for (int i = 0; i < PROC_NUM; i++) begin
      if (reset) begin
        cnt[i] <= '0;
      end else if (!dl_detect_in) begin
        if (!proc_blk[i])     cnt[i] <= '0;
        else if (cnt[i] != '1) cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < PROC_NUM; i++) begin
      stalled[i] = (cnt[i] >= CNT_W'(STALL_THRESH));
    end
  end

  aesl_dl_rr_arbiter #(.N(PROC_NUM)) u_arb (
    .req (stalled),
    .ptr (ptr),
    .gnt (arb_gnt)
  );

  always_comb begin
    arb_gnt_wide                 = '0;
    arb_gnt_wide[PROC_NUM-1:0]   = arb_gnt;
  end

  assign granted_stalled = |(token_grant & stalled);
  assign sched_busy      = (state != ST_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      ptr          <= rr_idx_t'(PROC_NUM - 1);
      grant_idx    <= '0;
      token_grant  <= '0;
      dl_in_vec    <= '0;
      hold_cnt     <= '0;
      hold_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          token_grant <= '0;
          dl_in_vec   <= '0;
          if (|stalled) state <= ST_GRANT;
        end
        ST_GRANT: begin
          hold_cnt  <= '0;
          dl_in_vec <= '0;
          if (|stalled) begin
            token_grant <= arb_gnt;
            grant_idx   <= onehot_to_idx(arb_gnt_wide);
            state       <= ST_HOLD;
          end else begin
            token_grant <= '0;
            state       <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          // token_clear outranks a dropping stall bit on the same edge.
          if (token_clear) begin
            ptr         <= grant_idx;
            token_grant <= '0;
            dl_in_vec   <= '0;
            state       <= ST_DRAIN;
          end else if (!granted_stalled) begin
            ptr         <= grant_idx;
            token_grant <= '0;
            dl_in_vec   <= '0;
            state       <= ST_IDLE;
          end else if (hold_cnt == HC_W'(HOLD_MAX - 1)) begin
            ptr          <= grant_idx;
            token_grant  <= '0;
            dl_in_vec    <= '0;
            hold_timeout <= 1'b1;
            state        <= ST_DRAIN;
          end else begin
            hold_cnt  <= hold_cnt + HC_W'(1);
            dl_in_vec <= token_grant & stalled;
          end
        end
        ST_DRAIN: begin
          token_grant <= '0;
          dl_in_vec   <= '0;
          state       <= ST_IDLE;
        end
        default: begin
          token_grant <= '0;
          dl_in_vec   <= '0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef AESL_DL_GLOBAL_STALL_EN
  always_ff @(posedge clock) begin
    if (reset) global_stall <= 1'b0;
    else       global_stall <= &stalled;
  end
`else
  assign global_stall = 1'b0;
`endif

endmodule

// File: tb/tb_aesl_deadlock_token_sched.sv
// Directed bench for aesl_deadlock_token_sched (STALL_THRESH=4, HOLD_MAX=8).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_aesl_deadlock_token_sched;

`ifdef AESL_DL_GLOBAL_STALL_EN
  localparam logic GS_EXP = 1'b1;
`else
  localparam logic GS_EXP = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic [3:0] proc_blk;
  logic       token_clear;
  logic       dl_detect_in;
  logic [3:0] token_grant;
  logic [3:0] dl_in_vec;
  logic       sched_busy;
  logic       hold_timeout;
  logic       global_stall;

  int checks   = 0;
  int failures = 0;

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  aesl_deadlock_token_sched #(
    .PROC_NUM     (4),
    .STALL_THRESH (4),
    .CNT_W        (8),
    .HOLD_MAX     (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .proc_blk     (proc_blk),
    .token_clear  (token_clear),
    .dl_detect_in (dl_detect_in),
    .token_grant  (token_grant),
    .dl_in_vec    (dl_in_vec),
    .sched_busy   (sched_busy),
    .hold_timeout (hold_timeout),
    .global_stall (global_stall)
  );

  // Driver helpers
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check4(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic check1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Bounded wait for a token to appear; an expired bound is a failed check.
  task automatic wait_grant(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (token_grant == 4'b0000 && n < max_cycles) begin
      step(1);
      n++;
    end
    if (token_grant == 4'b0000) begin
      checks++;
      failures++;
      $error("FAIL %s got=no_grant exp=grant_within_%0d", tag, max_cycles);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    proc_blk     = 4'b0000;
    token_clear  = 1'b0;
    dl_detect_in = 1'b0;
    step(2);
    check4("rst_grant", token_grant, 4'b0000);
    check4("rst_dlvec", dl_in_vec, 4'b0000);
    check1("rst_busy", sched_busy, 1'b0);
    check1("rst_timeout", hold_timeout, 1'b0);
    check1("rst_gstall", global_stall, 1'b0);

    // Counters frozen while dl_detect_in is high.
    reset        = 1'b0;
    dl_detect_in = 1'b1;
    proc_blk     = 4'b0010;
    step(6);
    check1("freeze_busy", sched_busy, 1'b0);

    // Basic latency: next edge is edge 0 with proc_blk=0010.
    dl_detect_in = 1'b0;
    step(4);
    check1("lat_idle_e3", sched_busy, 1'b0);
    step(1);
    check1("lat_grant_busy_e4", sched_busy, 1'b1);
    check4("lat_grant_tok_e4", token_grant, 4'b0000);
    step(1);
    check4("lat_tok_e5", token_grant, 4'b0010);
    check4("lat_dl_e5", dl_in_vec, 4'b0000);
    step(1);
    check4("lat_dl_e6", dl_in_vec, 4'b0010);

    // False alarm: stall bit drops one edge after proc_blk (registered counter).
    proc_blk = 4'b0000;
    step(1);
    check4("fa_still_hold", token_grant, 4'b0010);
    step(1);
    check1("fa_idle", sched_busy, 1'b0);
    check4("fa_tok", token_grant, 4'b0000);
    check4("fa_dl", dl_in_vec, 4'b0000);
    check1("fa_timeout", hold_timeout, 1'b0);

    // token_clear and stall drop on the same edge -> DRAIN.
    proc_blk = 4'b0010;
    wait_grant("prio_wait", 20);
    check4("prio_tok", token_grant, 4'b0010);
    proc_blk = 4'b0000;
    step(1);
    token_clear = 1'b1;
    step(1);
    token_clear = 1'b0;
    check1("prio_drain_busy", sched_busy, 1'b1);
    check4("prio_drain_tok", token_grant, 4'b0000);
    check4("prio_drain_dl", dl_in_vec, 4'b0000);
    step(1);
    check1("prio_idle", sched_busy, 1'b0);

    // Move ptr to 0, then run three handshakes with 1011 stalled.
    proc_blk = 4'b0001;
    wait_grant("rr_setup_wait", 20);
    check4("rr_setup_tok", token_grant, 4'b0001);
    proc_blk = 4'b1011;
    step(5);
    token_clear = 1'b1;
    step(1);
    token_clear = 1'b0;
    check1("rr_setup_drain", sched_busy, 1'b1);
    step(3);
    check4("rr_grant1", token_grant, 4'b0010);
    token_clear = 1'b1;
    step(1);
    token_clear = 1'b0;
    check4("rr_drain1_tok", token_grant, 4'b0000);
    check1("rr_drain1_busy", sched_busy, 1'b1);
    step(3);
    check4("rr_grant2", token_grant, 4'b1000);
    token_clear = 1'b1;
    step(1);
    token_clear = 1'b0;
    check4("rr_drain2_tok", token_grant, 4'b0000);
    check1("rr_drain2_busy", sched_busy, 1'b1);
    step(3);
    check4("rr_grant3", token_grant, 4'b0001);

    // HOLD timeout after 8 HOLD edges without token_clear.
    step(7);
    check1("to_before", hold_timeout, 1'b0);
    check4("to_before_tok", token_grant, 4'b0001);
    check4("to_before_dl", dl_in_vec, 4'b0001);
    step(1);
    check1("to_set", hold_timeout, 1'b1);
    check4("to_drain_tok", token_grant, 4'b0000);
    check1("to_drain_busy", sched_busy, 1'b1);
    step(1);
    check1("to_idle_busy", sched_busy, 1'b0);
    check1("to_sticky", hold_timeout, 1'b1);

    // Reset mid-HOLD; counters must restart from 0 (held by dl_detect_in).
    step(2);
    check4("mid_hold_tok", token_grant, 4'b0010);
    dl_detect_in = 1'b1;
    reset        = 1'b1;
    step(1);
    check4("rst2_tok", token_grant, 4'b0000);
    check4("rst2_dl", dl_in_vec, 4'b0000);
    check1("rst2_busy", sched_busy, 1'b0);
    check1("rst2_timeout", hold_timeout, 1'b0);
    check1("rst2_gstall", global_stall, 1'b0);
    reset = 1'b0;
    step(3);
    check1("rst2_cnt_zero", sched_busy, 1'b0);

    // All blocked: global stall; then stall vanishes before GRANT evaluates.
    dl_detect_in = 1'b0;
    proc_blk     = 4'hF;
    step(4);
    check1("gs_e4", global_stall, 1'b0);
    check1("gs_e4_busy", sched_busy, 1'b0);
    proc_blk = 4'h0;
    step(1);
    check1("gs_e5", global_stall, GS_EXP);
    check1("gs_grant_busy", sched_busy, 1'b1);
    step(1);
    check1("grant_empty_idle", sched_busy, 1'b0);
    check4("grant_empty_tok", token_grant, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
